// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-domain reset sequencer for the Synchronizer IP.
//
// The block synchronises the deassertion of an asynchronous active-low
// source reset into target_clk. It holds every channel asserted for at
// least STRETCH_CYCLES, and then releases the NUM_CH channels in ascending
// order, STAGGER_CYCLES apart. Each channel drives a registered
// active-high/active-low pair.
//
// Optional feature: define RESET_SEQUENCER_SW_REQ_EN to honour sw_rst_req
// as a synchronous restart of the sequence. When the macro is undefined,
// the port stays present but is ignored.
module reset_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_DEPTH     = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic              target_clk,
    input  logic              source_rst_n,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] target_rst,
    output logic [NUM_CH-1:0] target_rst_n,
    output logic              seq_done
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  sync_rst_n;

    state_t                state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic [NUM_CH-1:0]     rst_q, rst_nxt;
    logic [NUM_CH-1:0]     rst_n_q;
    logic                  done_q, done_nxt;

`ifndef RESET_SEQUENCER_SW_REQ_EN
    // The request port is kept for a uniform pinout but has no function here.
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
`endif

    // Deassertion synchroniser: cleared at once by the source reset, then fills with ones.
    always_ff @(posedge target_clk or negedge source_rst_n) begin
        if (!source_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[SYNC_DEPTH-1];

    // Sequencer state and registered channel outputs; the source reset asserts every channel at once.
    always_ff @(posedge target_clk or negedge source_rst_n) begin
        if (!source_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= IDX_W'(1);
            rst_q   <= '1;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            rst_q   <= rst_nxt;
            rst_n_q <= ~rst_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic: stretch, then release the channels one by one (a software request overrides).
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        rst_nxt   = rst_q;
        done_nxt  = done_q;

        case (state_q)
            ST_ASSERT: begin
                rst_nxt  = '1;
                done_nxt = 1'b0;
                if (!sync_rst_n) begin
                    cnt_nxt = '0;
                end else if (int'(cnt_q) == STRETCH_CYCLES - 1) begin
                    // The counter reaches STRETCH_CYCLES on this edge, so channel 0 goes now.
                    cnt_nxt = '0;
                    idx_nxt = IDX_W'(1);
                    if (NUM_CH == 1 || STAGGER_CYCLES == 0) begin
                        rst_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        rst_nxt[0] = 1'b0;
                        state_nxt  = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (int'(cnt_q) == STAGGER_CYCLES - 1) begin
                    cnt_nxt = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (i == int'(idx_q)) begin
                            rst_nxt[i] = 1'b0;
                        end
                    end
                    if (int'(idx_q) == NUM_CH - 1) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                cnt_nxt  = '0;
                rst_nxt  = '0;
                done_nxt = 1'b1;
            end

            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
                idx_nxt   = IDX_W'(1);
                rst_nxt   = '1;
                done_nxt  = 1'b0;
            end
        endcase

`ifdef RESET_SEQUENCER_SW_REQ_EN
        // A software request restarts the stretch without touching the synchroniser.
        if (sw_rst_req) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = IDX_W'(1);
            rst_nxt   = '1;
            done_nxt  = 1'b0;
        end
`endif
    end

    assign target_rst   = rst_q;
    assign target_rst_n = rst_n_q;
    assign seq_done     = done_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-domain reset sequencer for the Synchronizer IP. It takes one asynchronous active-low source reset and synchronises its deassertion into `target_clk`. It stretches the reset to a guaranteed minimum width, then releases `NUM_CH` downstream reset channels one at a time in fixed order, with a programmable stagger. It sits at the top of each clock domain, between the board/PLL reset and the per-subsystem reset inputs, and drives matched active-high/active-low pairs per channel.

## Interface
- `NUM_CH`, 4: number of sequenced reset channels; ≥1.
- `SYNC_DEPTH`, 3: flops in the deassertion synchroniser; ≥2.
- `STRETCH_CYCLES`, 16: minimum cycles all channels stay asserted after the synchronised release; ≥1.
- `STAGGER_CYCLES`, 4: cycles between consecutive channel releases; ≥0, where 0 means all channels release together.

- `target_clk`  in  1  the single clock; all outputs are registered on its rising edge.
- `source_rst_n`  in  1  reset, asynchronous, active-low. Assertion takes effect immediately; deassertion is synchronised internally.
- `sw_rst_req`  in  1  synchronous software reset request, level-sensitive, sampled on `target_clk`.
- `target_rst`  out  `NUM_CH`  per-channel reset, active-high.
- `target_rst_n`  out  `NUM_CH`  per-channel reset, active-low; always the bitwise complement of `target_rst`.
- `seq_done`  out  1  high once every channel is released.

## Operation
- **Synchroniser**
  - `SYNC_DEPTH`-flop chain, asynchronously cleared by `source_rst_n` low, shifting in 1.
  - Output `sync_rst_n`.
- **FSM states**
  - `ASSERT`: all channels asserted; the counter clears while `sync_rst_n`=0 and counts while it is 1. At count `STRETCH_CYCLES`, the block releases channel 0 and moves to `RELEASE`, or to `DONE` if `NUM_CH`=1 or `STAGGER_CYCLES`=0.
  - `RELEASE`: channel index `k` starts at 1. Every `STAGGER_CYCLES` edges the block releases channel `k` and increments `k`. Releasing channel `NUM_CH-1` moves the FSM to `DONE`.
  - `DONE`: all channels released and `seq_done`=1; the FSM holds here.
- **Channel behaviour**
  - Release order is strictly ascending index.
  - A released channel never reasserts except through a reset event.
- **Counter**
  - Width `$clog2(max(STRETCH_CYCLES,STAGGER_CYCLES)+1)`, unsigned.
  - Cleared on every state entry; it never wraps.
- **Reset values** (with `source_rst_n`=0, asynchronously)
  - `target_rst`='1 and `target_rst_n`='0.
  - `seq_done`=0.
  - FSM in `ASSERT`; counter and synchroniser at 0.
- **Reset mid-operation**: `source_rst_n` low in any state forces the reset values immediately. The full sequence, including synchroniser latency, reruns after the next deassertion.
- **Short source pulse**: a low pulse on `source_rst_n` narrower than one clock period still produces a full sequence.
- **Software request** (when configured in)
  - `sw_rst_req`=1 sampled at edge R, in any state, sets `target_rst`='1 and `seq_done`=0 after R. The FSM goes to `ASSERT` with the counter cleared.
  - The synchroniser is not cleared, so no `SYNC_DEPTH` delay applies.
  - Holding the request high holds the block in `ASSERT` with the counter at 0.
- **Simultaneous events**: `source_rst_n` low has priority over `sw_rst_req`, and `sw_rst_req` has priority over counter advance and channel release on the same edge.

## Timing
- Edge 1 is the first `target_clk` rising edge that samples `source_rst_n`=1; metastability resolution may add one edge.
- `sync_rst_n` rises after edge `SYNC_DEPTH`.
- Channel 0 releases at edge `SYNC_DEPTH+STRETCH_CYCLES`.
- Channel `k` releases at edge `SYNC_DEPTH+STRETCH_CYCLES+k*STAGGER_CYCLES`.
- `seq_done` rises on the same edge as the last channel release.
- After a software request at edge R, with `sw_rst_req` low at R+1 onward:
  - channel `k` releases at edge `R+STRETCH_CYCLES+k*STAGGER_CYCLES`.
  - Outputs assert after edge R; there is no asynchronous path from the request.
- Each `target_rst[k]`/`target_rst_n[k]` pair changes on the same edge.

## Configuration
- Macro `RESET_SEQUENCER_SW_REQ_EN`.
- **Defined**: `sw_rst_req` is honoured as described above.
- **Undefined**: the `sw_rst_req` port remains present but is ignored, and its request logic is compiled out. The only way to restart the sequence is `source_rst_n`.

## Test plan
- **Power-on sequence.** Parameters `NUM_CH`=4, `SYNC_DEPTH`=3, `STRETCH_CYCLES`=8, `STAGGER_CYCLES`=2; raise `source_rst_n` before edge 1.
  - Required: `target_rst` = 4'b1110 at edge 11, 4'b1100 at 13, 4'b1000 at 15, 4'b0000 at 17.
  - Required: `seq_done` rises at 17, and `target_rst_n` equals ~`target_rst` on every cycle.
- **Reset mid-sequence.** Same parameters; drive `source_rst_n` low asynchronously at edge 14, mid-cycle.
  - Required: `target_rst` goes to 4'b1111 and `seq_done` to 0 without waiting for a clock edge.
  - Required: after re-release, the full 17-edge sequence repeats.
- **Stagger of zero.** `STAGGER_CYCLES`=0, other parameters as above.
  - Required: all four channels release at edge 11, together with `seq_done`.
- **Software request from `DONE`.** Macro defined, FSM in `DONE`; pulse `sw_rst_req` for one cycle at edge R.
  - Required: `target_rst`=4'b1111 after R.
  - Required: channels release at R+8, R+10, R+12 and R+14, with `seq_done` rising at R+14.
- **Software request, held and compiled out.**
  - Macro defined, `sw_rst_req` held high for 20 cycles: the block stays at 4'b1111 throughout, and channel 0 releases 8 edges after the request drops.
  - Macro undefined: the same stimulus leaves `target_rst`=4'b0000 and `seq_done`=1 unchanged.
- **Glitch on the source reset.** Drive a 0.3-period low glitch on `source_rst_n` while in `DONE`.
  - Required: immediate assertion of all channels, followed by a complete sequence identical to the power-on sequence.
